// File: rtl/lfsr_multistep_if.sv
// Handshake bundle for lfsr_multistep: advance/load controls in, state and wrap pulse out.
// The master side drives en/load/seed; the slave side (the generator) drives value/wrap.
interface lfsr_multistep_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] value;
    logic             wrap;

    modport master (
        output en,
        output load,
        output seed,
        input  value,
        input  wrap
    );

    modport slave (
        input  en,
        input  load,
        input  seed,
        output value,
        output wrap
    );
endinterface

// File: rtl/lfsr_multistep.sv
// Extended XNOR LFSR (period 2^WIDTH) advancing STEPS positions per enabled cycle, with wrap pulse.
// Seed loading is compiled in only when LFSR_SEED_LOAD_EN is defined.
module lfsr_multistep #(
    parameter int WIDTH = 8,
    parameter int STEPS = 1
) (
    input logic           clk,
    input logic           rst,
    lfsr_multistep_if.slave bus
);

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_multistep: WIDTH must be in 3..32");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_multistep: STEPS must be in 1..WIDTH");
    end

    // XNOR tap masks indexed by width, bit n set for zero-based tap n.
    localparam logic [31:0] TAP_TABLE [3:32] = '{
        32'h0000_0006, 32'h0000_000C, 32'h0000_0014, 32'h0000_0030,
        32'h0000_0060, 32'h0000_00B8, 32'h0000_0110, 32'h0000_0240,
        32'h0000_0500, 32'h0000_0829, 32'h0000_100D, 32'h0000_2015,
        32'h0000_6000, 32'h0000_D008, 32'h0001_2000, 32'h0002_0400,
        32'h0004_0023, 32'h0009_0000, 32'h0014_0000, 32'h0030_0000,
        32'h0042_0000, 32'h00E1_0000, 32'h0120_0000, 32'h0200_0023,
        32'h0400_0013, 32'h0900_0000, 32'h1400_0000, 32'h2000_0029,
        32'h4800_0000, 32'h8020_0003
    };

    localparam logic [WIDTH-1:0] TAP_MASK = TAP_TABLE[WIDTH][WIDTH-1:0];

    // The AND term flips feedback at 0111..1 so the all-ones state is spliced into the cycle.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        logic fb;
        fb = ~(^(v & TAP_MASK)) ^ (&v[WIDTH-2:0]);
        return {v[WIDTH-2:0], fb};
    endfunction

    logic [WIDTH-1:0] step_state;
    logic             step_wrap;
    logic [WIDTH-1:0] next_value;
    logic             next_wrap;

    always_comb begin
        step_state = bus.value;
        step_wrap  = 1'b0;
        for (int k = 0; k < STEPS; k++) begin
            step_state = lfsr_step(step_state);
            if (step_state == '0) begin
                step_wrap = 1'b1;
            end
        end
    end

    // Load outranks en; a loaded seed never raises wrap, even when it is zero.
    always_comb begin
        next_value = bus.value;
        next_wrap  = 1'b0;
`ifdef LFSR_SEED_LOAD_EN
        if (bus.load) begin
            next_value = bus.seed;
        end else if (bus.en) begin
            next_value = step_state;
            next_wrap  = step_wrap;
        end
`else
        if (bus.en) begin
            next_value = step_state;
            next_wrap  = step_wrap;
        end
`endif
    end

`ifndef LFSR_SEED_LOAD_EN
    logic unused_load_inputs;
    assign unused_load_inputs = ^{bus.load, bus.seed};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.value <= '0;
            bus.wrap  <= 1'b0;
        end else begin
            bus.value <= next_value;
            bus.wrap  <= next_wrap;
        end
    end

endmodule

// File: tb/tb_lfsr_multistep.sv
// Self-checking bench for lfsr_multistep: five configurations run against a tap-list reference model.
// Load checks adapt to whether LFSR_SEED_LOAD_EN is defined.
module tb_lfsr_multistep;

    localparam int NDUT = 5;
    localparam int DW [NDUT] = '{4, 4, 8, 16, 5};
    localparam int DS [NDUT] = '{1, 2, 1, 1, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;

    int num_checks = 0;
    int num_errors = 0;

    bit          en_d   [NDUT];
    bit          ld_d   [NDUT];
    int          sd_d   [NDUT];
    int          m_val  [NDUT];
    bit          m_wrap [NDUT];
    logic [31:0] obs_val  [NDUT];
    logic        obs_wrap [NDUT];
    bit          seen [65536];

    always #5 clk = ~clk;

    lfsr_multistep_if #(.WIDTH(4))  bus0 ();
    lfsr_multistep_if #(.WIDTH(4))  bus1 ();
    lfsr_multistep_if #(.WIDTH(8))  bus2 ();
    lfsr_multistep_if #(.WIDTH(16)) bus3 ();
    lfsr_multistep_if #(.WIDTH(5))  bus4 ();

    assign bus0.en = en_d[0];  assign bus0.load = ld_d[0];  assign bus0.seed = sd_d[0][3:0];
    assign bus1.en = en_d[1];  assign bus1.load = ld_d[1];  assign bus1.seed = sd_d[1][3:0];
    assign bus2.en = en_d[2];  assign bus2.load = ld_d[2];  assign bus2.seed = sd_d[2][7:0];
    assign bus3.en = en_d[3];  assign bus3.load = ld_d[3];  assign bus3.seed = sd_d[3][15:0];
    assign bus4.en = en_d[4];  assign bus4.load = ld_d[4];  assign bus4.seed = sd_d[4][4:0];

    assign obs_val[0] = 32'(bus0.value);  assign obs_wrap[0] = bus0.wrap;
    assign obs_val[1] = 32'(bus1.value);  assign obs_wrap[1] = bus1.wrap;
    assign obs_val[2] = 32'(bus2.value);  assign obs_wrap[2] = bus2.wrap;
    assign obs_val[3] = 32'(bus3.value);  assign obs_wrap[3] = bus3.wrap;
    assign obs_val[4] = 32'(bus4.value);  assign obs_wrap[4] = bus4.wrap;

    lfsr_multistep #(.WIDTH(4),  .STEPS(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    lfsr_multistep #(.WIDTH(4),  .STEPS(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    lfsr_multistep #(.WIDTH(8),  .STEPS(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    lfsr_multistep #(.WIDTH(16), .STEPS(1)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    lfsr_multistep #(.WIDTH(5),  .STEPS(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Reference single step from the one-based XAPP052 tap list.
    function automatic int ref_step(input int w, input int v);
        int taps [4];
        int ntaps;
        int ones;
        int low_mask;
        int fb;
        ntaps = 2;
        taps  = '{0, 0, 0, 0};
        case (w)
            4:  taps = '{4, 3, 0, 0};
            5:  taps = '{5, 3, 0, 0};
            8:  begin taps = '{8, 6, 5, 4};   ntaps = 4; end
            16: begin taps = '{16, 15, 13, 4}; ntaps = 4; end
            default: ntaps = 0;
        endcase
        ones = 0;
        for (int t = 0; t < ntaps; t++) begin
            ones += (v >> (taps[t] - 1)) & 1;
        end
        fb = (ones % 2 == 0) ? 1 : 0;
        low_mask = (1 << (w - 1)) - 1;
        if ((v & low_mask) == low_mask) fb = fb ^ 1;
        return ((v << 1) & ((1 << w) - 1)) | fb;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One clock edge with the current drive values; the model follows the same rules.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            int v;
            bit hit;
            v   = m_val[i];
            hit = 1'b0;
`ifdef LFSR_SEED_LOAD_EN
            if (ld_d[i]) begin
                v = sd_d[i] & ((1 << DW[i]) - 1);
            end else if (en_d[i]) begin
                for (int k = 0; k < DS[i]; k++) begin
                    v = ref_step(DW[i], v);
                    if (v == 0) hit = 1'b1;
                end
            end
`else
            if (en_d[i]) begin
                for (int k = 0; k < DS[i]; k++) begin
                    v = ref_step(DW[i], v);
                    if (v == 0) hit = 1'b1;
                end
            end
`endif
            m_val[i]  = v;
            m_wrap[i] = hit;
        end
    endtask

    task automatic checkAll(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("%s_val%0d", tag, i), obs_val[i], 32'(m_val[i]));
            checkOutput($sformatf("%s_wrap%0d", tag, i), 32'(obs_wrap[i]), 32'(m_wrap[i]));
        end
    endtask

    task automatic clearDrive();
        for (int i = 0; i < NDUT; i++) begin
            en_d[i] = 1'b0;
            ld_d[i] = 1'b0;
            sd_d[i] = 0;
        end
    endtask

    // Full period with en held on one instance: distinct-state scoreboard and wrap count.
    task automatic runPeriod(input int idx);
        int n;
        int mism;
        int distinct;
        int wraps;
        int start;
        n        = 1 << DW[idx];
        mism     = 0;
        distinct = 0;
        wraps    = 0;
        start    = m_val[idx];
        clearDrive();
        en_d[idx] = 1'b1;
        for (int i = 0; i < n; i++) seen[i] = 1'b0;
        for (int c = 0; c < n; c++) begin
            applyStimulus();
            if (obs_val[idx] !== 32'(m_val[idx]) || obs_wrap[idx] !== m_wrap[idx]) mism++;
            if (!seen[obs_val[idx][15:0]]) distinct++;
            seen[obs_val[idx][15:0]] = 1'b1;
            if (obs_wrap[idx] === 1'b1) wraps++;
        end
        checkOutput($sformatf("period%0d_model", DW[idx]), 32'(mism), 32'd0);
        checkOutput($sformatf("period%0d_distinct", DW[idx]), 32'(distinct), 32'(n));
        checkOutput($sformatf("period%0d_wraps", DW[idx]), 32'(wraps), 32'd1);
        checkOutput($sformatf("period%0d_return", DW[idx]), obs_val[idx], 32'(start));
    endtask

    initial begin
        int wr0;
        int wr1;
        clearDrive();
        for (int i = 0; i < NDUT; i++) begin
            m_val[i]  = 0;
            m_wrap[i] = 1'b0;
        end

        // Reset is asynchronous: outputs are zero before any clock edge.
        #2;
        checkAll("reset_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        checkAll("reset_held");
        rst = 1'b0;

        // WIDTH=4 with STEPS 1 and 2, en held from reset release.
        wr0 = 0;
        wr1 = 0;
        en_d[0] = 1'b1;
        en_d[1] = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            applyStimulus();
            checkAll("w4run");
            if (obs_wrap[0] === 1'b1) wr0++;
            if (obs_wrap[1] === 1'b1) wr1++;
            if (c == 1) begin
                checkOutput("w4s1_first", obs_val[0], 32'h1);
                checkOutput("w4s2_first", obs_val[1], 32'h3);
            end
            if (c == 2) checkOutput("w4s2_second", obs_val[1], 32'hF);
            if (c == 4) checkOutput("w4s1_fourth", obs_val[0], 32'hF);
            if (c == 5) checkOutput("w4s1_fifth", obs_val[0], 32'hE);
            if (c == 8) checkOutput("w4s2_period", obs_val[1], 32'h0);
            if (c == 16) begin
                checkOutput("w4s1_return", obs_val[0], 32'h0);
                checkOutput("w4s1_wrap", 32'(obs_wrap[0]), 32'h1);
            end
        end
        checkOutput("w4s1_wrap_count", 32'(wr0), 32'd1);
        checkOutput("w4s2_wrap_count", 32'(wr1), 32'd2);

        runPeriod(2);
        runPeriod(3);

        // Randomized en/load/seed on every instance.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NDUT; i++) begin
                en_d[i] = ($urandom_range(0, 3) != 0);
                ld_d[i] = ($urandom_range(0, 7) == 0);
                case ($urandom_range(0, 5))
                    0:       sd_d[i] = 0;
                    1:       sd_d[i] = (1 << DW[i]) - 1;
                    default: sd_d[i] = int'($urandom) & ((1 << DW[i]) - 1);
                endcase
            end
            applyStimulus();
            checkAll("random");
        end

        clearDrive();
`ifdef LFSR_SEED_LOAD_EN
        en_d[2] = 1'b1;
        ld_d[2] = 1'b1;
        sd_d[2] = 'hFF;
        applyStimulus();
        checkOutput("load_ff_val", obs_val[2], 32'hFF);
        checkOutput("load_ff_wrap", 32'(obs_wrap[2]), 32'h0);
        ld_d[2] = 1'b0;
        applyStimulus();
        checkOutput("step_after_ff", obs_val[2], 32'hFE);
        ld_d[2] = 1'b1;
        en_d[2] = 1'b0;
        sd_d[2] = 0;
        applyStimulus();
        checkOutput("load_zero_val", obs_val[2], 32'h0);
        checkOutput("load_zero_wrap", 32'(obs_wrap[2]), 32'h0);
        ld_d[2] = 1'b0;
        en_d[2] = 1'b1;
        applyStimulus();
        checkOutput("step_after_zero", obs_val[2], 32'h1);
`else
        en_d[2] = 1'b1;
        ld_d[2] = 1'b1;
        sd_d[2] = 'hFF;
        for (int c = 0; c < 4; c++) begin
            applyStimulus();
            checkOutput("load_ignored_val", obs_val[2], 32'(m_val[2]));
            checkOutput("load_ignored_wrap", 32'(obs_wrap[2]), 32'(m_wrap[2]));
        end
`endif

        // en low: every state holds and wrap stays low.
        clearDrive();
        for (int c = 0; c < 10; c++) begin
            applyStimulus();
            checkAll("hold");
            for (int i = 0; i < NDUT; i++) begin
                checkOutput($sformatf("hold_wrap%0d", i), 32'(obs_wrap[i]), 32'h0);
            end
        end

        // Mid-run async reset between edges.
        en_d[0] = 1'b1;
        for (int c = 0; c < 3 && m_val[0] == 0; c++) applyStimulus();
        applyStimulus();
        checkOutput("pre_reset_nonzero", 32'(obs_val[0] != 0), 32'h1);
        clearDrive();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            m_val[i]  = 0;
            m_wrap[i] = 1'b0;
        end
        checkAll("rst_mid");
        @(posedge clk);
        #1;
        checkAll("rst_mid_held");
        rst = 1'b0;
        en_d[0] = 1'b1;
        applyStimulus();
        checkOutput("post_reset_first", obs_val[0], 32'h1);
        checkAll("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
